mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

MEM-stage load/store unit of the 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register, and drives the data bus for loads and stores. It stalls the pipeline while a bus transaction is outstanding. It presents the writeback triple (we, data, reg index) plus the debug PC+4 to MEM/WB, and never lets a discarded instruction (pc4 bit 31 set) touch memory.

## Interface
- No parameters; data path fixed at 32 bits.
- clk  in  1  pipeline clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- ex_valid_i  in  1  EX/MEM slot holds an instruction
- ex_mem_re_i / ex_mem_we_i  in  1/1  load / store (never both)
- ex_funct3_i  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_addr_i  in  32  effective address (ALU result)
- ex_wdata_i  in  32  store data (rs2)
- ex_reg_we_i  in  1  instruction writes rd
- ex_wD_i  in  32  ALU result for non-loads
- ex_wR_i  in  5  rd index
- ex_pc4_i_debug  in  32  PC+4; bit 31 set = discarded
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  32  lane-replicated store data
- dbus_ack_i  in  1  transaction complete; rdata valid this cycle
- dbus_rdata_i  in  32  read word
- mem_reg_we_o / mem_wD_o / mem_wR_o / mem_pc4_o_debug  out  1/32/5/32  to MEM/WB
- mem_stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- mem_misalign_o  out  1  misaligned access flagged (see Configuration)

## Operation
- "Live mem op" = ex_valid_i & (re|we) & ~ex_pc4_i_debug[31].
- FSM states: IDLE, REQ, DONE. Reset → IDLE.
- IDLE: live mem op → register addr/we/be/wdata/funct3/addr[1:0], go REQ. Otherwise stay.
- REQ: dbus_req_o=1 with registered fields, held stable until ack. dbus_ack_i → capture rdata extracted and extended into load_q, go DONE.
- DONE: go IDLE unconditionally.
- dbus_ack_i outside REQ is ignored.
- mem_stall_o = live mem op & state≠DONE (combinational).
- Upstream holds EX/MEM stable while stalled.
- Non-mem or discarded ops pass through combinationally with zero added latency and no stall.
- Writeback outputs, combinational:
  - mem_wR_o = ex_wR_i; mem_pc4_o_debug = ex_pc4_i_debug.
  - mem_reg_we_o = ex_valid_i & ex_reg_we_i; forced 0 while stalled.
  - mem_wD_o = load_q when load in DONE, else ex_wD_i.
- Store lanes:
  - SB: be=1<<addr[1:0], wdata={4{b}}.
  - SH: be=addr[1]?1100:0011, wdata={2{h}}.
  - SW: be=1111.
- Load extract: byte/half selected by addr[1:0]/addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Undefined funct3 values (011, 110, 111) are treated as W.

## Timing
- Reset values: state IDLE, dbus_req_o 0, dbus_we_o 0, dbus_addr_o 0, dbus_be_o 0, dbus_wdata_o 0, load_q 0, mem_misalign_o 0.
- Combinational outputs follow their inputs during reset.
- Op first presented at cycle 0 → req asserted cycles 1..k, where k is the ack cycle → DONE at k+1.
- Stall is high cycles 0..k and low at k+1, when MEM/WB captures the result.
- Minimum occupancy is 3 cycles (ack in the first req cycle).
- Back-to-back mem ops: the next op enters IDLE at k+2. No request is issued in the DONE cycle.
- rst_n low mid-transaction drops req immediately and discards the transaction. The bus must tolerate an abandoned request.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - Live H with addr[0]=1, or W with addr[1:0]≠0, issues no request and raises no stall.
  - mem_misalign_o is registered high for exactly one cycle, the cycle after the op is presented in IDLE.
  - mem_reg_we_o is forced 0 for that op.
- LSU_ALIGN_CHECK_EN undefined:
  - No check. Halfword uses addr[1] only; word ignores addr[1:0].
  - mem_misalign_o tied 0.

## Test plan
- LW at 0x100, ack same cycle as first req, rdata 0xDEADBEEF → stall 2 cycles, then mem_wD_o=0xDEADBEEF with mem_reg_we_o=1 for 1 cycle.
- LB at 0x103, rdata 0x80FF_FF7F → wD=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202, data 0x1234ABCD, ack after 3 wait cycles → addr 0x200, be=1100, wdata=0xABCDABCD, req held 4 cycles, stall 5 cycles.
- SW with pc4[31]=1 → no req, no stall, mem_reg_we_o=0.
- Reset asserted in REQ → req drops asynchronously. After release: state IDLE, a stray ack is ignored, and the next ADD passes wD through with no stall.
- With LSU_ALIGN_CHECK_EN: LW at 0x101 → no req, mem_misalign_o pulses 1 cycle, mem_reg_we_o=0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving a single-outstanding data bus.
// Optional misaligned-access trap is enabled by defining LSU_ALIGN_CHECK_EN.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic        ex_mem_re_i,
    input  logic        ex_mem_we_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        ex_reg_we_i,
    input  logic [31:0] ex_wD_i,
    input  logic [4:0]  ex_wR_i,
    input  logic [31:0] ex_pc4_i_debug,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        mem_reg_we_o,
    output logic [31:0] mem_wD_o,
    output logic [4:0]  mem_wR_o,
    output logic [31:0] mem_pc4_o_debug,
    output logic        mem_stall_o,
    output logic        mem_misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] load_q;

    logic        live_op;
    logic        misaligned;
    logic        issue_op;
    logic        is_byte;
    logic        is_half;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    // Undefined funct3 encodings fall out of these decodes as word accesses.
    assign is_byte = (ex_funct3_i[1:0] == 2'b00);
    assign is_half = (ex_funct3_i[1:0] == 2'b01);
    assign live_op = ex_valid_i & (ex_mem_re_i | ex_mem_we_i) & ~ex_pc4_i_debug[31];

`ifdef LSU_ALIGN_CHECK_EN
    logic misalign_q;

    assign misaligned = live_op & ((is_half & ex_addr_i[0]) |
                                   (~is_byte & ~is_half & (ex_addr_i[1:0] != 2'b00)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state_q == IDLE) & misaligned;
        end
    end

    assign mem_misalign_o = misalign_q;
`else
    assign misaligned     = 1'b0;
    assign mem_misalign_o = 1'b0;
`endif

    assign issue_op = live_op & ~misaligned;

    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lo);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {lo, 3'b000};
        b       = shifted[7:0];
        h       = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h000000, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0000, h};
            default: return word;
        endcase
    endfunction

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = ex_wdata_i;
        if (is_byte) begin
            be_d    = 4'b0001 << ex_addr_i[1:0];
            wdata_d = {4{ex_wdata_i[7:0]}};
        end else if (is_half) begin
            be_d    = ex_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{ex_wdata_i[15:0]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue_op) state_d = REQ;
            REQ:     if (dbus_ack_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus fields are latched on issue so they stay stable for the whole request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_be_o    <= '0;
            dbus_wdata_o <= '0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            load_q       <= '0;
        end else begin
            dbus_req_o <= (state_d == REQ);
            if (state_q == IDLE && issue_op) begin
                dbus_we_o    <= ex_mem_we_i;
                dbus_addr_o  <= {ex_addr_i[31:2], 2'b00};
                dbus_be_o    <= be_d;
                dbus_wdata_o <= wdata_d;
                funct3_q     <= ex_funct3_i;
                addr_lo_q    <= ex_addr_i[1:0];
            end
            if (state_q == REQ && dbus_ack_i) begin
                load_q <= extract_load(dbus_rdata_i, funct3_q, addr_lo_q);
            end
        end
    end

    always_comb begin
        mem_wR_o        = ex_wR_i;
        mem_pc4_o_debug = ex_pc4_i_debug;
        mem_stall_o     = issue_op & (state_q != DONE);
        mem_reg_we_o    = ex_valid_i & ex_reg_we_i & ~mem_stall_o & ~misaligned;
        mem_wD_o        = ((state_q == DONE) && ex_mem_re_i) ? load_q : ex_wD_i;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu with hand-computed expectations.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_i;
    logic        ex_mem_re_i;
    logic        ex_mem_we_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_reg_we_i;
    logic [31:0] ex_wD_i;
    logic [4:0]  ex_wR_i;
    logic [31:0] ex_pc4_i_debug;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic        mem_reg_we_o;
    logic [31:0] mem_wD_o;
    logic [4:0]  mem_wR_o;
    logic [31:0] mem_pc4_o_debug;
    logic        mem_stall_o;
    logic        mem_misalign_o;

    int checks = 0;
    int errors = 0;

    mem_stage_lsu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid_i     (ex_valid_i),
        .ex_mem_re_i    (ex_mem_re_i),
        .ex_mem_we_i    (ex_mem_we_i),
        .ex_funct3_i    (ex_funct3_i),
        .ex_addr_i      (ex_addr_i),
        .ex_wdata_i     (ex_wdata_i),
        .ex_reg_we_i    (ex_reg_we_i),
        .ex_wD_i        (ex_wD_i),
        .ex_wR_i        (ex_wR_i),
        .ex_pc4_i_debug (ex_pc4_i_debug),
        .dbus_req_o     (dbus_req_o),
        .dbus_we_o      (dbus_we_o),
        .dbus_addr_o    (dbus_addr_o),
        .dbus_be_o      (dbus_be_o),
        .dbus_wdata_o   (dbus_wdata_o),
        .dbus_ack_i     (dbus_ack_i),
        .dbus_rdata_i   (dbus_rdata_i),
        .mem_reg_we_o   (mem_reg_we_o),
        .mem_wD_o       (mem_wD_o),
        .mem_wR_o       (mem_wR_o),
        .mem_pc4_o_debug(mem_pc4_o_debug),
        .mem_stall_o    (mem_stall_o),
        .mem_misalign_o (mem_misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_op(input logic v, input logic re, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic rwe,
                            input logic [31:0] wd, input logic [31:0] pc4);
        ex_valid_i     = v;
        ex_mem_re_i    = re;
        ex_mem_we_i    = we;
        ex_funct3_i    = f3;
        ex_addr_i      = addr;
        ex_wdata_i     = wdata;
        ex_reg_we_i    = rwe;
        ex_wD_i        = wd;
        ex_wR_i        = 5'd7;
        ex_pc4_i_debug = pc4;
    endtask

    // Presents one live mem op, acks after 'waits' extra request cycles, checks every cycle.
    task automatic run_mem(input string tag, input logic re, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                           input int unsigned waits, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_wd, input logic exp_rwe);
        @(posedge clk); #1;
        drive_op(1'b1, re, we, f3, addr, wdata, re, 32'h11111111, 32'h00000404);
        dbus_ack_i = 1'b0;
        @(negedge clk);
        check({tag, " c0 stall"}, {31'd0, mem_stall_o}, 32'd1);
        check({tag, " c0 req"}, {31'd0, dbus_req_o}, 32'd0);
        for (int unsigned i = 0; i <= waits; i++) begin
            @(posedge clk); #1;
            dbus_ack_i   = (i == waits);
            dbus_rdata_i = (i == waits) ? rdata : 32'h0;
            @(negedge clk);
            check({tag, " req"}, {31'd0, dbus_req_o}, 32'd1);
            check({tag, " stall"}, {31'd0, mem_stall_o}, 32'd1);
            check({tag, " rwe stalled"}, {31'd0, mem_reg_we_o}, 32'd0);
            if (i == 0) begin
                check({tag, " addr"}, dbus_addr_o, exp_addr);
                check({tag, " we"}, {31'd0, dbus_we_o}, {31'd0, we});
                if (we) begin
                    check({tag, " be"}, {28'd0, dbus_be_o}, {28'd0, exp_be});
                    check({tag, " wdata"}, dbus_wdata_o, exp_wdata);
                end
            end
        end
        @(posedge clk); #1;
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = 32'h0;
        @(negedge clk);
        check({tag, " done stall"}, {31'd0, mem_stall_o}, 32'd0);
        check({tag, " done req"}, {31'd0, dbus_req_o}, 32'd0);
        check({tag, " done rwe"}, {31'd0, mem_reg_we_o}, {31'd0, exp_rwe});
        check({tag, " done wD"}, mem_wD_o, exp_wd);
    endtask

    initial begin
        rst_n        = 1'b0;
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = 32'h0;
        drive_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("rst req", {31'd0, dbus_req_o}, 32'd0);
        check("rst we", {31'd0, dbus_we_o}, 32'd0);
        check("rst addr", dbus_addr_o, 32'd0);
        check("rst be", {28'd0, dbus_be_o}, 32'd0);
        check("rst wdata", dbus_wdata_o, 32'd0);
        check("rst misalign", {31'd0, mem_misalign_o}, 32'd0);
        check("rst stall", {31'd0, mem_stall_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_mem("LW", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b1);
        run_mem("LB", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 0,
                32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b1);
        run_mem("LBU", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 0,
                32'h100, 4'b1000, 32'h0, 32'h00000080, 1'b1);
        run_mem("LH", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 1,
                32'h100, 4'b1100, 32'h0, 32'hFFFF8001, 1'b1);
        run_mem("LHU", 1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h8001F234, 0,
                32'h100, 4'b0011, 32'h0, 32'h0000F234, 1'b1);
        run_mem("L011", 1'b1, 1'b0, 3'b011, 32'h104, 32'h0, 32'h12345678, 0,
                32'h104, 4'b1111, 32'h0, 32'h12345678, 1'b1);
        run_mem("SH", 1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3,
                32'h200, 4'b1100, 32'hABCDABCD, 32'h11111111, 1'b0);
        run_mem("SB", 1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0,
                32'h200, 4'b0010, 32'hA5A5A5A5, 32'h11111111, 1'b0);
        run_mem("SW", 1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 1,
                32'h300, 4'b1111, 32'hCAFEF00D, 32'h11111111, 1'b0);

        // Discarded store never reaches the bus.
        @(posedge clk); #1;
        drive_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h300, 32'h55555555, 1'b0, 32'h22222222, 32'h80000010);
        @(negedge clk);
        check("disc stall", {31'd0, mem_stall_o}, 32'd0);
        check("disc rwe", {31'd0, mem_reg_we_o}, 32'd0);
        check("disc pc4", mem_pc4_o_debug, 32'h80000010);
        @(posedge clk); #1;
        @(negedge clk);
        check("disc req", {31'd0, dbus_req_o}, 32'd0);

        // Reset while a request is outstanding.
        @(posedge clk); #1;
        drive_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 32'h0, 32'h00000404);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid req before", {31'd0, dbus_req_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid req async", {31'd0, dbus_req_o}, 32'd0);
        @(posedge clk); #1;
        drive_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        dbus_ack_i   = 1'b1;
        dbus_rdata_i = 32'hFFFFFFFF;
        @(negedge clk);
        @(posedge clk); #1;
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = 32'h0;
        drive_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 32'h000000AB, 32'h00000500);
        @(negedge clk);
        check("stray req", {31'd0, dbus_req_o}, 32'd0);
        check("add stall", {31'd0, mem_stall_o}, 32'd0);
        check("add rwe", {31'd0, mem_reg_we_o}, 32'd1);
        check("add wD", mem_wD_o, 32'h000000AB);
        check("add wR", {27'd0, mem_wR_o}, 32'd7);
        run_mem("LW post", 1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'hA5A55A5A, 0,
                32'h108, 4'b1111, 32'h0, 32'hA5A55A5A, 1'b1);

`ifdef LSU_ALIGN_CHECK_EN
        @(posedge clk); #1;
        drive_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 32'h0, 32'h00000600);
        @(negedge clk);
        check("mis stall", {31'd0, mem_stall_o}, 32'd0);
        check("mis rwe", {31'd0, mem_reg_we_o}, 32'd0);
        check("mis flag c0", {31'd0, mem_misalign_o}, 32'd0);
        @(posedge clk); #1;
        drive_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("mis flag c1", {31'd0, mem_misalign_o}, 32'd1);
        check("mis req", {31'd0, dbus_req_o}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mis flag c2", {31'd0, mem_misalign_o}, 32'd0);
`else
        run_mem("LW mis", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0BADF00D, 0,
                32'h100, 4'b1111, 32'h0, 32'h0BADF00D, 1'b1);
        check("nomis flag", {31'd0, mem_misalign_o}, 32'd0);
`endif

        @(posedge clk); #1;
        drive_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
